mem_bus_arbiter: RTL

//  Shares the single external memory bus between instruction fetch (IF) and the load/store

---
 rtl/mem_bus_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - IF/MEM external bus arbiter, MEM priority; optional watchdog via ARB_TIMEOUT_EN
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [3:0]  mem_sel,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        bus_req,
    output logic        bus_we,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        stall_o,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE, XFER_MEM, XFER_IF, DONE} state_t;

    state_t state, state_nxt;
    logic   grant_if;
    logic   err_q;
    logic   in_xfer;
    logic   timeout_hit;

    assign in_xfer = (state == XFER_MEM) || (state == XFER_IF);

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt;

    // Counter is zero whenever a transfer starts because every grant leaves IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt <= '0;
        end else if (state == IDLE) begin
            tmo_cnt <= '0;
        end else if (in_xfer && !bus_ack) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign timeout_hit = in_xfer && !bus_ack && (tmo_cnt == TERMINAL);
`else
    assign timeout_hit = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (mem_req) begin
                    state_nxt = XFER_MEM;
                end else if (if_req) begin
                    state_nxt = XFER_IF;
                end
            end
            XFER_MEM, XFER_IF: begin
                if (bus_ack || timeout_hit) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus_req   = in_xfer;
        if_ready  = (state == DONE) && grant_if;
        mem_ready = (state == DONE) && !grant_if;
        bus_err   = (state == DONE) && err_q;
    end

    assign stall_o = (if_req & ~if_ready) | (mem_req & ~mem_ready);

    // Bus fields are latched at grant so the requester may change its inputs freely afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_if  <= 1'b0;
            err_q     <= 1'b0;
            bus_we    <= 1'b0;
            bus_sel   <= 4'h0;
            bus_addr  <= 32'h0;
            bus_wdata <= 32'h0;
            if_rdata  <= 32'h0;
            mem_rdata <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    err_q <= 1'b0;
                    if (mem_req) begin
                        grant_if  <= 1'b0;
                        bus_we    <= mem_we;
                        bus_sel   <= mem_sel;
                        bus_addr  <= mem_addr;
                        bus_wdata <= mem_wdata;
                    end else if (if_req) begin
                        grant_if  <= 1'b1;
                        bus_we    <= 1'b0;
                        bus_sel   <= 4'hF;
                        bus_addr  <= if_addr;
                        bus_wdata <= 32'h0;
                    end
                end
                XFER_MEM, XFER_IF: begin
                    if (bus_ack) begin
                        if (state == XFER_IF) begin
                            if_rdata <= bus_rdata;
                        end else if (!bus_we) begin
                            mem_rdata <= bus_rdata;
                        end
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                        if (state == XFER_IF) begin
                            if_rdata <= 32'h0;
                        end else begin
                            mem_rdata <= 32'h0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
